// File: rtl/cache_mem_arbiter.sv
// Shares one cache-line memory port between the I-cache and the D-cache.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN alternates grants under contention; default is fixed D-over-I.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [2:0]        o_dbg_state
);

    // Handshake: a cache holds x_read/x_write until its one-cycle x_resp; the arbiter
    // holds one memory strobe until the one-cycle mem_resp. Nothing else is sampled.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_i_resp;
    logic              r_d_resp;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_line;

    logic w_d_req;
    logic w_any_req;
    logic w_grant_d;

    assign w_d_req   = d_read | d_write;
    assign w_any_req = w_d_req | i_read;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic r_last_d;
    // Under contention the cache that was not served last wins.
    assign w_grant_d = w_d_req & ~(i_read & r_last_d);
`else
    assign w_grant_d = w_d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_resp    <= 1'b0;
            r_d_resp    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_line      <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        if (w_grant_d) begin
                            r_addr      <= d_address;
                            r_mem_write <= d_write;
                            r_mem_read  <= ~d_write;
                            if (d_write) begin
                                r_wdata <= d_wdata;
                            end
                            r_state     <= SERVE_D;
                        end else begin
                            r_addr      <= i_address;
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_state     <= SERVE_I;
                        end
                    end
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        r_line     <= mem_rdata;
                        r_mem_read <= 1'b0;
                        r_i_resp   <= 1'b1;
                        r_state    <= RESP_I;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        // A writeback leaves the line buffer untouched.
                        if (r_mem_read) begin
                            r_line <= mem_rdata;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_d_resp    <= 1'b1;
                        r_state     <= RESP_D;
                    end
                end
                RESP_I: begin
                    r_i_resp <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    r_last_d <= 1'b0;
`endif
                    r_state  <= IDLE;
                end
                RESP_D: begin
                    r_d_resp <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    r_last_d <= 1'b1;
`endif
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata     = r_line;
    assign d_rdata     = r_line;
    assign i_resp      = r_i_resp;
    assign d_resp      = r_d_resp;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign o_dbg_state = r_state;

`ifndef SYNTHESIS
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
        else $error("cache_mem_arbiter: d_read and d_write asserted together");
    a_resp_exclusive: assert property (@(posedge clk) !(r_i_resp && r_d_resp))
        else $error("cache_mem_arbiter: i_resp and d_resp high together");
    a_strobe_exclusive: assert property (@(posedge clk) !(r_mem_read && r_mem_write))
        else $error("cache_mem_arbiter: mem_read and mem_write high together");
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios, then randomized traffic
// compared every cycle against a cycle-count based transaction model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;
  logic [2:0]        o_dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk256(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Transaction view: a grant starts a transaction whose strobe lasts from the next cycle
  // through the mem_resp cycle; the response follows one cycle later and the arbiter
  // listens for new requests again two cycles after mem_resp.
  int                cyc = 0;
  bit                m_valid = 1'b0;
  bit                m_serving = 1'b0;
  bit                m_who_d = 1'b0;
  bit                m_wr = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  logic [LINE_W-1:0] m_line = '0;
  int                m_idle_from = 0;
  int                m_resp_cyc = -1;
  bit                m_resp_d = 1'b0;
  bit                m_resp_wr = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  bit                m_last_d = 1'b0;
`endif

  always @(posedge clk) begin : model
    int c;
    bit d_req;
    bit want_d;
    c = cyc;
    d_req = d_read || d_write;
    if (rst) begin
      m_valid     = 1'b1;
      m_serving   = 1'b0;
      m_resp_cyc  = -1;
      m_idle_from = c + 1;
      m_line      = '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      m_last_d    = 1'b0;
`endif
    end else if (m_valid) begin
      if (m_serving) begin
        if (mem_resp) begin
          if (!m_wr) m_line = mem_rdata;
          m_serving   = 1'b0;
          m_resp_cyc  = c + 1;
          m_resp_d    = m_who_d;
          m_resp_wr   = m_wr;
          m_idle_from = c + 2;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          m_last_d    = m_who_d;
`endif
        end
      end else if (c >= m_idle_from && (i_read || d_req)) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        if (d_req && i_read) want_d = !m_last_d;
        else want_d = d_req;
`else
        want_d = d_req;
`endif
        m_serving = 1'b1;
        m_who_d   = want_d;
        if (want_d) begin
          m_addr = d_address;
          m_wr   = d_write;
          if (d_write) m_wdata = d_wdata;
        end else begin
          m_addr = i_address;
          m_wr   = 1'b0;
        end
      end
    end
    cyc = c + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk1("mem_read", mem_read, m_serving && !m_wr);
      chk1("mem_write", mem_write, m_serving && m_wr);
      chk1("i_resp", i_resp, (cyc == m_resp_cyc) && !m_resp_d);
      chk1("d_resp", d_resp, (cyc == m_resp_cyc) && m_resp_d);
      if (m_serving) chk32("mem_address", mem_address, m_addr);
      if (m_serving && m_wr) chk256("mem_wdata", mem_wdata, m_wdata);
      if (cyc == m_resp_cyc && !m_resp_wr) begin
        if (m_resp_d) chk256("d_rdata", d_rdata, m_line);
        else chk256("i_rdata", i_rdata, m_line);
      end
    end
  end

  // ---------------- memory responder ----------------
  int                mem_lat_mode = -1;
  bit                spurious_en = 1'b0;
  bit                mem_use_fixed = 1'b0;
  logic [LINE_W-1:0] mem_fixed_data = '0;

  initial begin : mem_model
    int cnt;
    cnt = -1;
    forever begin
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      if (mem_read || mem_write) begin
        if (cnt < 0) cnt = (mem_lat_mode < 0) ? int'($urandom_range(0, 3)) : mem_lat_mode;
        if (cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_use_fixed ? mem_fixed_data : rand_line();
          cnt = -1;
        end else begin
          cnt--;
        end
      end else begin
        cnt = -1;
        if (spurious_en && $urandom_range(0, 7) == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = rand_line();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (mem_read || mem_write) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no memory strobe within %0d cycles", name, max_cyc);
  endtask

  task automatic wait_resp(input string name, input bit is_d, input int max_cyc, output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (is_d ? d_resp : i_resp) begin
        at_cyc = cyc;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles", name, max_cyc);
  endtask

  task automatic step_random();
    if (rst) rst = 1'b0;
    else if ($urandom_range(0, 599) == 0) rst = 1'b1;
    if (i_resp) i_read = 1'b0;
    else if (i_read) begin
      if ($urandom_range(0, 31) == 0) i_read = 1'b0;
      if ($urandom_range(0, 3) == 0) i_address = $urandom;
    end else if ($urandom_range(0, 2) == 0) begin
      i_read = 1'b1;
      i_address = $urandom;
    end
    if (d_resp) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else if (d_read || d_write) begin
      if ($urandom_range(0, 31) == 0) begin
        d_read = 1'b0;
        d_write = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        d_address = $urandom;
        d_wdata = rand_line();
      end
    end else if ($urandom_range(0, 2) == 0) begin
      d_write = ($urandom_range(0, 1) == 1);
      d_read = !d_write;
      d_address = $urandom;
      d_wdata = rand_line();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int r1;
    int r2;
    bit first_d;
    logic [LINE_W-1:0] line_aa;
    logic [LINE_W-1:0] line_wb;
    line_aa = {8{32'hAAAA_AAAA}};
    line_wb = {8{32'h1234_5678}};

    repeat (3) tick();
    chk1("reset_state_idle", o_dbg_state == 3'd0, 1'b1);
    chk1("reset_mem_read", mem_read, 1'b0);
    chk1("reset_i_resp", i_resp, 1'b0);
    chk256("reset_line", i_rdata, '0);
    rst = 1'b0;

    // single I read, memory answers after 3 cycles
    mem_lat_mode = 3;
    mem_use_fixed = 1'b1;
    mem_fixed_data = line_aa;
    i_address = 32'h0000_0060;
    i_read = 1'b1;
    tick();
    chk1("iread_strobe_t1", mem_read, 1'b1);
    chk32("iread_addr", mem_address, 32'h0000_0060);
    wait_resp("iread_resp", 1'b0, 20, r1);
    chk256("iread_rdata", i_rdata, line_aa);
    chk1("iread_no_d_resp", d_resp, 1'b0);
    i_read = 1'b0;

    // D writeback
    mem_lat_mode = 2;
    mem_use_fixed = 1'b0;
    d_address = 32'h1000_0020;
    d_wdata = line_wb;
    d_write = 1'b1;
    wait_strobe("dwb_strobe", 5);
    chk1("dwb_mem_write", mem_write, 1'b1);
    chk1("dwb_mem_read", mem_read, 1'b0);
    chk256("dwb_wdata", mem_wdata, line_wb);
    wait_resp("dwb_resp", 1'b1, 20, r1);
    d_write = 1'b0;

    // simultaneous requests right after reset: D first in both builds
    do_reset();
    mem_lat_mode = 1;
    i_address = 32'h0000_0200;
    d_address = 32'h0000_0300;
    i_read = 1'b1;
    d_read = 1'b1;
    wait_strobe("pair1_strobe", 5);
    chk32("pair1_first", mem_address, 32'h0000_0300);
    wait_resp("pair1_d", 1'b1, 20, r1);
    d_read = 1'b0;
    wait_resp("pair1_i", 1'b0, 20, r2);
    i_read = 1'b0;
    chk1("pair1_gap", (r2 - r1) >= 4, 1'b1);
    d_address = 32'h0000_0400;
    d_read = 1'b1;
    wait_resp("solo_d", 1'b1, 20, r1);
    d_read = 1'b0;
    // second pair: last served was D
    i_address = 32'h0000_0500;
    d_address = 32'h0000_0600;
    i_read = 1'b1;
    d_read = 1'b1;
    wait_strobe("pair2_strobe", 5);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
    chk32("pair2_first", mem_address, 32'h0000_0500);
`else
    first_d = 1'b1;
    chk32("pair2_first", mem_address, 32'h0000_0600);
`endif
    wait_resp("pair2_a", first_d, 20, r1);
    if (first_d) d_read = 1'b0;
    else i_read = 1'b0;
    wait_resp("pair2_b", !first_d, 20, r1);
    i_read = 1'b0;
    d_read = 1'b0;

    // address change and drop while serving
    mem_lat_mode = 4;
    d_address = 32'h2000_0040;
    d_read = 1'b1;
    wait_strobe("drop_strobe", 5);
    d_address = 32'hDEAD_0000;
    tick();
    d_read = 1'b0;
    tick();
    chk32("drop_addr_held", mem_address, 32'h2000_0040);
    chk1("drop_strobe_held", mem_read, 1'b1);
    wait_resp("drop_resp", 1'b1, 20, r1);
    tick();
    chk1("drop_back_idle", o_dbg_state == 3'd0, 1'b1);

    // reset while a read is outstanding
    mem_lat_mode = 50;
    i_address = 32'h0000_0080;
    i_read = 1'b1;
    wait_strobe("rst_strobe", 5);
    tick();
    rst = 1'b1;
    tick();
    chk1("rst_mid_mem_read", mem_read, 1'b0);
    chk1("rst_mid_idle", o_dbg_state == 3'd0, 1'b1);
    chk1("rst_mid_no_resp", i_resp, 1'b0);
    mem_lat_mode = 2;
    rst = 1'b0;
    wait_resp("rst_regrant", 1'b0, 20, r1);
    i_read = 1'b0;

    // back-to-back I reads, zero memory latency
    mem_lat_mode = 0;
    i_address = 32'h0000_0100;
    i_read = 1'b1;
    wait_resp("b2b_first", 1'b0, 20, r1);
    i_read = 1'b0;
    tick();
    chk1("b2b_gap_no_strobe", mem_read, 1'b0);
    i_address = 32'h0000_0120;
    i_read = 1'b1;
    tick();
    chk1("b2b_next_strobe", mem_read, 1'b1);
    chk32("b2b_next_addr", mem_address, 32'h0000_0120);
    wait_resp("b2b_second", 1'b0, 20, r2);
    i_read = 1'b0;
    chk32("b2b_resp_spacing", r2 - r1, 32'd3);

    // randomized traffic with spurious memory responses and occasional resets
    mem_lat_mode = -1;
    spurious_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      step_random();
    end
    rst = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
